// File: rtl/matrix_stream_loader.sv
// Loads a dimension header plus matrices A and B from a beat stream into two
// element buffers and offers them to the multiplier through a ready/ack handshake.
//
// state    | meaning
// IDLE     | waiting for the first header field; element beats are dropped
// HDR      | collecting c1, r2, c2; validates dimensions on the last field
// LOAD_A   | assembling and storing r1*c1 elements of A
// LOAD_B   | assembling and storing r2*c2 elements of B
// READY    | both matrices held for the consumer; input stalled until mat_ack
// ERR      | error latched; waits for a new header beat
module matrix_stream_loader #(
  parameter int IN_W    = 4,
  parameter int ELEM_W  = 32,
  parameter int MAX_DIM = 4,
  parameter int AW      = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_valid,
  input  logic              in_hdr,
  output logic              in_ready,
  output logic [IN_W-1:0]   r1,
  output logic [IN_W-1:0]   c1,
  output logic [IN_W-1:0]   r2,
  output logic [IN_W-1:0]   c2,
  output logic              mat_ready,
  input  logic              mat_ack,
  input  logic              rd_sel,
  input  logic [AW-1:0]     rd_addr,
  output logic [ELEM_W-1:0] rd_data,
  output logic              err,
  output logic [2:0]        err_code
);

  localparam int BPE   = ELEM_W / IN_W;
  localparam int DEPTH = MAX_DIM * MAX_DIM;
  localparam int BC_W  = (BPE > 1) ? $clog2(BPE) : 1;
  localparam int PW    = 2 * IN_W;
  localparam logic [IN_W-1:0] MAX_D     = IN_W'(MAX_DIM);
  localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(BPE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_LOAD_A, S_LOAD_B, S_READY, S_ERR
  } state_t;

  state_t state_q, state_d;

  logic [1:0]           hdr_cnt;
  logic [BC_W-1:0]      beat_cnt;
  logic [PW-1:0]        elem_idx;
  logic [ELEM_W-1:0]    acc;
  logic [ELEM_W+IN_W-1:0] shifted;
  logic [ELEM_W-1:0]    wr_word;
  logic [PW-1:0]        prod_a, prod_b;
  logic                 accept, hdr_beat, elem_beat, loading, elem_done;
  logic                 last_a, last_b, hdr_last, dims_bad, dims_mismatch;

  logic [ELEM_W-1:0] buf_a [DEPTH];
  logic [ELEM_W-1:0] buf_b [DEPTH];

  function automatic logic dim_bad(input logic [IN_W-1:0] d);
    return (d == '0) || (d > MAX_D);
  endfunction

  assign in_ready  = (state_q != S_READY);
  assign mat_ready = (state_q == S_READY);
  assign err       = (state_q == S_ERR);

  assign accept    = in_valid && in_ready;
  assign hdr_beat  = accept && in_hdr;
  assign elem_beat = accept && !in_hdr;
  assign loading   = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
  assign elem_done = elem_beat && loading && (beat_cnt == LAST_BEAT);

  // Most significant beat arrives first, so each beat shifts in at the bottom.
  assign shifted = {acc, in_data};
  assign wr_word = shifted[ELEM_W-1:0];

  assign prod_a = PW'(r1) * PW'(c1);
  assign prod_b = PW'(r2) * PW'(c2);
  assign last_a = (elem_idx + 1'b1) == prod_a;
  assign last_b = (elem_idx + 1'b1) == prod_b;

  // The final header beat is still on in_data when the dimensions are checked.
  assign hdr_last      = (hdr_cnt == 2'd3);
  assign dims_bad      = dim_bad(r1) || dim_bad(c1) || dim_bad(r2) || dim_bad(in_data);
  assign dims_mismatch = (c1 != r2);

  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (hdr_beat) state_d = S_HDR;
      S_HDR: begin
        if (elem_beat)
          state_d = S_ERR;
        else if (hdr_beat && hdr_last)
          state_d = (dims_bad || dims_mismatch) ? S_ERR : S_LOAD_A;
      end
      S_LOAD_A: begin
        if (hdr_beat)                 state_d = S_ERR;
        else if (elem_done && last_a) state_d = S_LOAD_B;
      end
      S_LOAD_B: begin
        if (hdr_beat)                 state_d = S_ERR;
        else if (elem_done && last_b) state_d = S_READY;
      end
      S_READY:  if (mat_ack) state_d = S_IDLE;
      S_ERR:    if (hdr_beat) state_d = S_HDR;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r1       <= '0;
      c1       <= '0;
      r2       <= '0;
      c2       <= '0;
      hdr_cnt  <= '0;
      beat_cnt <= '0;
      elem_idx <= '0;
      acc      <= '0;
      err_code <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_ERR: begin
          if (hdr_beat) begin
            r1       <= in_data;
            hdr_cnt  <= 2'd1;
            err_code <= '0;
          end
        end
        S_HDR: begin
          if (elem_beat) begin
            err_code <= 3'd1;
          end else if (hdr_beat) begin
            hdr_cnt <= hdr_cnt + 2'd1;
            case (hdr_cnt)
              2'd1:    c1 <= in_data;
              2'd2:    r2 <= in_data;
              default: c2 <= in_data;
            endcase
            if (hdr_last) begin
              if (dims_bad)           err_code <= 3'd2;
              else if (dims_mismatch) err_code <= 3'd3;
              elem_idx <= '0;
              beat_cnt <= '0;
            end
          end
        end
        S_LOAD_A, S_LOAD_B: begin
          if (hdr_beat) begin
            err_code <= 3'd4;
          end else if (elem_beat) begin
            acc <= wr_word;
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              if ((state_q == S_LOAD_A && last_a) || (state_q == S_LOAD_B && last_b))
                elem_idx <= '0;
              else
                elem_idx <= elem_idx + 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (elem_done && state_q == S_LOAD_A) buf_a[elem_idx[AW-1:0]] <= wr_word;
    if (elem_done && state_q == S_LOAD_B) buf_b[elem_idx[AW-1:0]] <= wr_word;
  end

  always_ff @(posedge CLK) begin
    if (RST)         rd_data <= '0;
    else if (rd_sel) rd_data <= buf_b[rd_addr];
    else             rd_data <= buf_a[rd_addr];
  end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Directed bench for matrix_stream_loader with a transaction-level reference
// model compared against the outputs every cycle.
module tb_matrix_stream_loader;

  localparam int BPE = 8;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  in_data;
  logic        in_valid, in_hdr, in_ready;
  logic [3:0]  r1, c1, r2, c2;
  logic        mat_ready, mat_ack, rd_sel;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic        err;
  logic [2:0]  err_code;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  matrix_stream_loader dut (
    .CLK(CLK), .RST(RST), .in_data(in_data), .in_valid(in_valid), .in_hdr(in_hdr),
    .in_ready(in_ready), .r1(r1), .c1(c1), .r2(r2), .c2(c2), .mat_ready(mat_ready),
    .mat_ack(mat_ack), .rd_sel(rd_sel), .rd_addr(rd_addr), .rd_data(rd_data),
    .err(err), .err_code(err_code)
  );

  always #5 CLK = ~CLK;

  // Reference model: phase 0 idle, 1 header, 2 loading A, 3 loading B, 4 ready, 5 error
  int          ph = 0, hc = 0, nb = 0, code = 0;
  int          dims [4];
  logic [31:0] acc_m;
  logic [31:0] ma [16];
  logic [31:0] mb [16];
  bit          va [16];
  bit          vb [16];
  logic [31:0] m_rd;
  bit          m_rd_known = 0;

  task automatic model_beat(input bit h, input logic [3:0] d);
    int idx, need;
    case (ph)
      0: if (h) begin dims[0] = int'(d); hc = 1; ph = 1; end
      1: begin
        if (!h) begin
          ph = 5; code = 1;
        end else begin
          dims[hc] = int'(d);
          hc++;
          if (hc == 4) begin
            bit bad = 0;
            for (int k = 0; k < 4; k++) if (dims[k] == 0 || dims[k] > 4) bad = 1;
            if (bad)                      begin ph = 5; code = 2; end
            else if (dims[1] != dims[2])  begin ph = 5; code = 3; end
            else                          begin ph = 2; nb = 0; acc_m = 0; end
          end
        end
      end
      2, 3: begin
        if (h) begin
          ph = 5; code = 4;
        end else begin
          acc_m = (acc_m << 4) | 32'(d);
          nb++;
          if (nb % BPE == 0) begin
            idx  = nb / BPE - 1;
            need = (ph == 2) ? dims[0] * dims[1] : dims[2] * dims[3];
            if (ph == 2) begin ma[idx] = acc_m; va[idx] = 1; end
            else         begin mb[idx] = acc_m; vb[idx] = 1; end
            if (nb / BPE == need) begin ph++; nb = 0; end
          end
        end
      end
      5: if (h) begin code = 0; dims[0] = int'(d); hc = 1; ph = 1; end
      default: ;
    endcase
  endtask

  initial begin
    for (int k = 0; k < 4; k++) dims[k] = 0;
    forever begin
      @(posedge CLK);
      if (RST) begin
        ph = 0; hc = 0; nb = 0; code = 0;
        for (int k = 0; k < 4; k++) dims[k] = 0;
        m_rd = 0; m_rd_known = 1;
      end else begin
        m_rd_known = rd_sel ? vb[rd_addr] : va[rd_addr];
        m_rd       = rd_sel ? mb[rd_addr] : ma[rd_addr];
        if (ph == 4) begin
          if (mat_ack) ph = 0;
        end else if (in_valid) begin
          model_beat(in_hdr, in_data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      if (chk_en) begin
        check("ctrl", {in_ready, mat_ready, err, err_code, r1, c1, r2, c2},
              {ph != 4, ph == 4, ph == 5, 3'(code), 4'(dims[0]), 4'(dims[1]), 4'(dims[2]), 4'(dims[3])});
        if (m_rd_known) check("rd_data", rd_data, m_rd);
      end
    end
  end

  // Caller sits at a negedge; returns at the negedge after the beat was taken.
  task automatic send(input bit h, input logic [3:0] d, input bit gaps);
    int n = 0;
    if (gaps) repeat ($urandom_range(0, 1)) @(negedge CLK);
    in_valid = 1; in_hdr = h; in_data = d;
    while (!in_ready && n < 50) begin @(negedge CLK); n++; end
    if (!in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: in_ready stuck at 0, required 1");
    end
    @(negedge CLK);
    in_valid = 0;
  endtask

  task automatic send_hdr(input int a, input int b, input int c, input int d, input bit gaps);
    send(1'b1, 4'(a), gaps); send(1'b1, 4'(b), gaps);
    send(1'b1, 4'(c), gaps); send(1'b1, 4'(d), gaps);
  endtask

  task automatic send_elem(input logic [31:0] v, input bit gaps);
    for (int b = BPE - 1; b >= 0; b--) send(1'b0, v[b*4 +: 4], gaps);
  endtask

  task automatic rd_chk(input string name, input bit sel, input int addr, input logic [31:0] exp);
    rd_sel = sel; rd_addr = 4'(addr);
    @(negedge CLK);
    check(name, rd_data, exp);
  endtask

  task automatic ack();
    mat_ack = 1;
    @(negedge CLK);
    mat_ack = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1; in_data = 0; in_valid = 0; in_hdr = 0; mat_ack = 0; rd_sel = 0; rd_addr = 0;
    repeat (3) @(negedge CLK);
    chk_en = 1;
    check("reset_outputs", {in_ready, mat_ready, err, err_code, r1, c1, r2, c2, rd_data},
          {1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 32'h0});
    RST = 0;
    @(negedge CLK);

    // 2x2 by 2x2, continuous valid
    send_hdr(2, 2, 2, 2, 0);
    for (int i = 0; i < 4; i++) send_elem(32'h11111111 * (i + 1), 0);
    for (int i = 0; i < 4; i++) send_elem(32'h11111111 * (i + 5), 0);
    check("mat_ready_after_load", mat_ready, 1);
    rd_chk("rd_A3", 0, 3, 32'h44444444);
    rd_chk("rd_B0", 1, 0, 32'h55555555);
    in_valid = 1; in_hdr = 0; in_data = 4'h5;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check("ready_stall", {in_ready, mat_ready}, 2'b01);
    end
    in_valid = 0;
    ack();
    check("after_ack", {in_ready, mat_ready}, 2'b10);

    // C1 != R2, then recovery with a 1x1 by 1x1 load
    send_hdr(2, 3, 2, 2, 0);
    check("code3", {err, err_code}, {1'b1, 3'd3});
    send(1'b1, 4'd1, 0);
    check("err_clear_on_hdr", err, 0);
    send(1'b1, 4'd1, 0); send(1'b1, 4'd1, 0); send(1'b1, 4'd1, 0);
    send_elem(32'hDEADBEEF, 0);
    send_elem(32'h01234567, 0);
    check("dims_1111", {mat_ready, r1, c1, r2, c2}, {1'b1, 16'h1111});
    rd_chk("rd_A0_1x1", 0, 0, 32'hDEADBEEF);
    rd_chk("rd_B0_1x1", 1, 0, 32'h01234567);
    ack();

    // dimension range checks and header-during-load
    send_hdr(0, 2, 2, 2, 0);
    check("code2_zero", err_code, 3'd2);
    send_hdr(5, 1, 1, 1, 0);
    check("code2_big", err_code, 3'd2);
    send_hdr(3, 1, 1, 1, 0);
    check("dim3_ok", {err, err_code}, {1'b0, 3'd0});
    for (int i = 0; i < 5; i++) send(1'b0, 4'(i), 0);
    send(1'b1, 4'd2, 0);
    check("code4", {err, err_code}, {1'b1, 3'd4});
    send(1'b1, 4'd2, 0);
    send(1'b0, 4'd3, 0);
    check("code1", {err, err_code}, {1'b1, 3'd1});

    // 3x1 by 1x2 with random valid gaps
    send_hdr(3, 1, 1, 2, 1);
    for (int i = 0; i < 3; i++) send_elem(32'hCAFE0000 + i, 1);
    for (int i = 0; i < 2; i++) send_elem(32'hBEEF0010 + i, 1);
    check("gap_ready", mat_ready, 1);
    for (int i = 0; i < 3; i++) rd_chk("gap_rd_A", 0, i, 32'hCAFE0000 + i);
    for (int i = 0; i < 2; i++) rd_chk("gap_rd_B", 1, i, 32'hBEEF0010 + i);
    ack();

    // reset in the middle of LOAD_B, then a fresh load
    send_hdr(2, 2, 2, 2, 0);
    for (int i = 0; i < 4; i++) send_elem(32'hA5A5A500 + i, 0);
    for (int i = 0; i < 2; i++) send_elem(32'h5A5A5A00 + i, 0);
    for (int i = 0; i < 3; i++) send(1'b0, 4'hF, 0);
    RST = 1;
    @(negedge CLK);
    check("mid_reset", {in_ready, mat_ready, err, err_code, r1, c1, r2, c2, rd_data},
          {1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 32'h0});
    RST = 0;
    send_hdr(2, 2, 2, 2, 0);
    for (int i = 0; i < 4; i++) send_elem(32'h0F0F0F00 + i, 0);
    for (int i = 0; i < 4; i++) send_elem(32'h70707070 + i, 0);
    check("reload_ready", mat_ready, 1);
    rd_chk("reload_A2", 0, 2, 32'h0F0F0F02);
    rd_chk("reload_B0", 1, 0, 32'h70707070);
    rd_chk("reload_B3", 1, 3, 32'h70707073);
    ack();
    repeat (2) @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
